// File: rtl/cache_fill_fsm.sv
// Cache block fill controller.
// On a miss, it requests the eight 16-bit words of the aligned block from the
// memory arbitrator. It then writes each returned word into the data array,
// and writes the tag/valid entry together with the last word.
// Address issue and data return are counted separately, because the memory
// may return words while later addresses are still being requested.
//
// state | meaning
// IDLE  | no fill outstanding; waiting for a miss
// FILL  | issuing block addresses and collecting returned words

module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        service,
  input  logic        data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        mem_request,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  data_word,
  output logic [15:0] fill_data,
  output logic        write_tag_array
);

  localparam logic [3:0] ISSUE_LIMIT = 4'(BLOCK_WORDS);
  localparam logic [2:0] LAST_WORD   = 3'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state;
  logic [15:0] base;
  logic [3:0]  issue_cnt;
  logic [2:0]  recv_cnt;

  // Outputs decode directly from the registered state.
  // The write strobes also follow data_valid in the same cycle.
  // The strobes are held off while rst is high, so that a fill aborted by
  // reset can never mark its block valid.
  assign fsm_busy         = (state == FILL);
  assign mem_request      = fsm_busy && (issue_cnt < ISSUE_LIMIT);
  assign memory_address   = base + {12'd0, issue_cnt[2:0], 1'b0};
  assign write_data_array = fsm_busy && data_valid && !rst;
  assign data_word        = recv_cnt;
  assign write_tag_array  = write_data_array && (recv_cnt == LAST_WORD);
  assign fill_data        = memory_data;

  // State, block base and the issue/receive counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base      <= {miss_address[15:4], 4'h0};
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (mem_request && service) begin
            issue_cnt <= issue_cnt + 4'd1;
          end
          if (data_valid) begin
            recv_cnt <= recv_cnt + 3'd1;
            if (recv_cnt == LAST_WORD) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
